mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage datapath and controller of the multi-cycle core. It sits directly downstream of the stage sequencer.
- Latches the EX-stage memory operation when the sequencer's EX-to-MEM write enable fires.
- Runs a req/ready transaction on the data-memory port, performing byte-lane steering for stores and extraction plus extension for loads.
- Drives mem_force back to the sequencer, which holds the MEM stage until the access completes. It also presents the writeback data and writeback qualifier for the MEM-stage RF write.

Parameters:
- ADDR_W, 32, data-memory address width.
- RD_W, 4, destination-register index width.
- TIMEOUT_CYCLES, 15, maximum wait for dmem_ready. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  core clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- exmem_wen  in  1  EX-to-MEM latch enable from the stage sequencer.
- ex_is_store  in  1  1 = store, 0 = load; sampled with exmem_wen.
- ex_size  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
- ex_signed  in  1  load sign-extend (1) or zero-extend (0).
- ex_addr  in  ADDR_W  effective address.
- ex_wdata  in  32  store data, right-aligned.
- ex_rd  in  RD_W  load destination register.
- mem_force  out  1  to sequencer: 1 keeps the sequencer in MEM.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  ADDR_W  word-aligned address (addr[1:0] forced to 00).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ready  in  1  memory accepts/completes the request this cycle.
- dmem_rdata  in  32  read data, valid when dmem_ready=1.
- wb_data  out  32  extended load result.
- wb_rd  out  RD_W  latched destination register.
- wb_valid  out  1  1 = MEM-stage RF write must take effect.
- mem_err  out  1  misaligned access (or timeout, if enabled); 1-cycle pulse.

Behaviour:
- Reset: state IDLE. The following outputs are 0: mem_force, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, wb_data, wb_rd, wb_valid, mem_err.
  - Reset wins over every other input.
  - Reset mid-transaction drops dmem_req at the next edge; any late dmem_ready is ignored.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - mem_force=0.
  - On exmem_wen=1: latch all ex_* inputs.
  - If aligned: go to ACCESS.
  - If misaligned (half with addr[0]=1, or word with addr[1:0]!=00): go to DONE with the error flag set and no bus request.
- ACCESS:
  - dmem_req=1, with dmem_we, dmem_addr, dmem_be and dmem_wdata held constant.
  - mem_force=1.
  - On dmem_ready=1: capture the formatted read data (loads) into wb_data and go to DONE.
  - Minimum dwell is 1 cycle; the dwell is unbounded without the optional feature.
- DONE:
  - mem_force=0, dmem_req=0.
  - wb_valid=1 only for an aligned load that completed without error.
  - mem_err=1 if the error flag is set.
  - Next state is IDLE unconditionally.
- MEM-stage length, as seen by the sequencer: (dmem_ready latency + 2) cycles. The error path takes 1 cycle.
- exmem_wen while in ACCESS or DONE is a protocol violation. It is ignored, and the latched operation is unchanged.
- dmem_ready while dmem_req=0 is ignored.
- Byte enables from size and addr[1:0]:
  - byte: one-hot at lane addr[1:0].
  - half: 0011 for addr[1]=0, 1100 for addr[1]=1.
  - word: 1111.
- Store data lane replication:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: as-is.
- Load extraction:
  - byte: select lane addr[1:0].
  - half: select lane addr[1].
  - Extend to 32 bits per ex_signed. The word case passes through.
- wb_data and wb_rd hold their values until the next capture. wb_valid and mem_err are high for DONE only.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A counter is cleared on entry to ACCESS and increments each ACCESS cycle.
  - If the count reaches TIMEOUT_CYCLES without dmem_ready, drop dmem_req, set the error flag and go to DONE. wb_valid=0 and mem_err=1 in that cycle.
  - dmem_ready in the same cycle as the timeout: ready wins (normal completion).
- MEM_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely.

Test Plan:
- Word load, addr 0x100, dmem_ready one cycle after req, rdata 0xDEADBEEF:
  - mem_force=1 for 2 cycles.
  - Then DONE with wb_data=0xDEADBEEF, wb_valid=1, wb_rd=latched rd.
- Signed byte load, addr 0x103, rdata 0x80FF7F01 -> dmem_addr=0x100, wb_data=0xFFFFFF80. The same access unsigned -> 0x00000080.
- Halfword store, addr 0x206, wdata 0x0000ABCD, ready held low 3 cycles:
  - dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1.
  - All four held stable during the wait.
  - DONE with wb_valid=0.
- Misaligned word load, addr 0x101 -> no dmem_req ever, 1-cycle DONE with mem_err=1, wb_valid=0, mem_force never high.
- Reset asserted in the 2nd ACCESS cycle -> dmem_req=0 and all outputs 0 the next cycle. A dmem_ready pulse afterwards produces no wb_valid.
- With MEM_TIMEOUT_EN defined and TIMEOUT_CYCLES=4, ready never asserted -> mem_force=1 for exactly 4 cycles, then DONE with mem_err=1, then IDLE.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Data-memory port bundle between the MEM-stage access unit and data memory.
//   master : drives dmem_req/we/addr/be/wdata, samples dmem_ready/rdata
//   slave  : the memory side
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [3:0]        dmem_be;
  logic [31:0]       dmem_wdata;
  logic              dmem_ready;
  logic [31:0]       dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage access unit of the multi-cycle core.
// Latches the EX-stage memory op on exmem_wen, runs one req/ready transaction
// on the data-memory port (store lane steering, load extraction/extension),
// holds the sequencer in MEM via mem_force and presents the writeback result.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   exmem_wen, ex_*       EX-stage memory operation and its latch enable
//   mem_force             keeps the sequencer in MEM while ACCESS is active
//   dmem (master)         data-memory port (req/we/addr/be/wdata, ready/rdata)
//   wb_data/wb_rd/wb_valid  MEM-stage register-file write
//   mem_err               one-cycle error pulse (misalignment / timeout)
// Optional: define MEM_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES
// cycles without dmem_ready.
module mem_access_unit #(
  parameter int ADDR_W         = 32,
  parameter int RD_W           = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exmem_wen,
  input  logic              ex_is_store,
  input  logic [1:0]        ex_size,
  input  logic              ex_signed,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic [RD_W-1:0]   ex_rd,
  output logic              mem_force,
  mem_access_unit_if.master dmem,
  output logic [31:0]       wb_data,
  output logic [RD_W-1:0]   wb_rd,
  output logic              wb_valid,
  output logic              mem_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state, state_nxt;
  logic              st_q, sgn_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              misaligned, timeout;
  logic [3:0]        be_fmt;
  logic [31:0]       wd_fmt, ld_fmt, ld_sh;

  // size 11 falls into the word cases through size[1]
  assign misaligned = (ex_size == 2'b01 && ex_addr[0]) ||
                      (ex_size[1] && ex_addr[1:0] != 2'b00);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;

  // Zero while IDLE so every ACCESS starts from a cleared count.
  always_ff @(posedge clk) begin
    if (reset)                to_cnt <= '0;
    else if (state == IDLE)   to_cnt <= '0;
    else if (state == ACCESS) to_cnt <= to_cnt + CNT_W'(1);
  end

  // Ready in the expiring cycle still completes normally.
  assign timeout = (state == ACCESS) && !dmem.dmem_ready &&
                   (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (exmem_wen) state_nxt = misaligned ? DONE : ACCESS;
      ACCESS:  if (dmem.dmem_ready || timeout) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operation latch and writeback capture. exmem_wen outside IDLE is
  // a sequencer protocol violation and is dropped here.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= 1'b0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      if (state == IDLE && exmem_wen) begin
        st_q    <= ex_is_store;
        sgn_q   <= ex_signed;
        size_q  <= ex_size;
        addr_q  <= ex_addr;
        wdata_q <= ex_wdata;
        wb_rd   <= ex_rd;
        err_q   <= misaligned;
      end
      if (state == ACCESS && dmem.dmem_ready && !st_q) wb_data <= ld_fmt;
      if (timeout) err_q <= 1'b1;
    end
  end

  // Lane steering / extraction from the latched size and address
  always_comb begin
    be_fmt = 4'hF;
    wd_fmt = wdata_q;
    ld_fmt = dmem.dmem_rdata;
    ld_sh  = '0;
    case (size_q)
      2'b00: begin
        be_fmt = 4'b0001 << addr_q[1:0];
        wd_fmt = {4{wdata_q[7:0]}};
        ld_sh  = dmem.dmem_rdata >> {addr_q[1:0], 3'b000};
        ld_fmt = {{24{sgn_q & ld_sh[7]}}, ld_sh[7:0]};
      end
      2'b01: begin
        be_fmt = addr_q[1] ? 4'b1100 : 4'b0011;
        wd_fmt = {2{wdata_q[15:0]}};
        ld_sh  = dmem.dmem_rdata >> {addr_q[1], 4'b0000};
        ld_fmt = {{16{sgn_q & ld_sh[15]}}, ld_sh[15:0]};
      end
      default: ;
    endcase
  end

  // Outputs: bus fields are only driven during ACCESS, so they stay
  // constant for the whole request and read 0 otherwise.
  always_comb begin
    mem_force       = 1'b0;
    dmem.dmem_req   = 1'b0;
    dmem.dmem_we    = 1'b0;
    dmem.dmem_addr  = '0;
    dmem.dmem_be    = '0;
    dmem.dmem_wdata = '0;
    wb_valid        = 1'b0;
    mem_err         = 1'b0;
    case (state)
      ACCESS: begin
        mem_force       = 1'b1;
        dmem.dmem_req   = 1'b1;
        dmem.dmem_we    = st_q;
        dmem.dmem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        dmem.dmem_be    = be_fmt;
        dmem.dmem_wdata = st_q ? wd_fmt : 32'h0;
      end
      DONE: begin
        wb_valid = !st_q && !err_q;
        mem_err  = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  localparam int ADDR_W = 32;
  localparam int RD_W   = 4;
`ifdef MEM_TIMEOUT_EN
  localparam int TO_LIM = 4;
`else
  localparam int TO_LIM = 1000000;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              exmem_wen, ex_is_store, ex_signed;
  logic [1:0]        ex_size;
  logic [ADDR_W-1:0] ex_addr;
  logic [31:0]       ex_wdata;
  logic [RD_W-1:0]   ex_rd;
  logic              mem_force, wb_valid, mem_err;
  logic [31:0]       wb_data;
  logic [RD_W-1:0]   wb_rd;

  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(ADDR_W)) dmem ();

  mem_access_unit #(.ADDR_W(ADDR_W), .RD_W(RD_W), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .exmem_wen(exmem_wen), .ex_is_store(ex_is_store),
    .ex_size(ex_size), .ex_signed(ex_signed), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_rd(ex_rd), .mem_force(mem_force), .dmem(dmem), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_valid(wb_valid), .mem_err(mem_err)
  );

  int tests = 0, fails = 0;
  bit chk_en = 0;

  // expected values for the current cycle
  logic        e_force, e_req, e_we, e_valid, e_err;
  logic [31:0] e_addr, e_wdata, e_wb_data;
  logic [3:0]  e_be, e_wb_rd;

  // running observations
  int force_cnt = 0, req_cnt = 0, err_cnt = 0;
  logic [31:0] last_addr, last_wdata;
  logic [3:0]  last_be;
  logic        last_we;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_force", 32'(mem_force), 32'(e_force));
      chk("dmem_req", 32'(dmem.dmem_req), 32'(e_req));
      chk("dmem_we", 32'(dmem.dmem_we), 32'(e_we));
      chk("dmem_addr", dmem.dmem_addr, e_addr);
      chk("dmem_be", 32'(dmem.dmem_be), 32'(e_be));
      chk("dmem_wdata", dmem.dmem_wdata, e_wdata);
      chk("wb_valid", 32'(wb_valid), 32'(e_valid));
      chk("mem_err", 32'(mem_err), 32'(e_err));
      chk("wb_data", wb_data, e_wb_data);
      chk("wb_rd", 32'(wb_rd), 32'(e_wb_rd));
    end
    if (mem_force) force_cnt++;
    if (mem_err) err_cnt++;
    if (dmem.dmem_req) begin
      req_cnt++;
      last_addr  = dmem.dmem_addr;
      last_wdata = dmem.dmem_wdata;
      last_be    = dmem.dmem_be;
      last_we    = dmem.dmem_we;
    end
  end

  // ---- behavioural model helpers ----
  function automatic bit m_mis(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd1) return (a % 2) != 0;
    if (sz >= 2'd2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 4'(1 << (a % 4));
    if (sz == 2'd1) return ((a % 4) >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return (d % 256) * 32'h01010101;
    if (sz == 2'd1) return (d % 65536) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_ld(input logic [1:0] sz, input bit sgn,
                                       input logic [31:0] a, input logic [31:0] r);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (r >> (8 * (a % 4))) % 256;
      if (sgn && v >= 128) v = v + 32'hFFFFFF00;
      return v;
    end
    if (sz == 2'd1) begin
      v = (r >> (((a % 4) >= 2) ? 16 : 0)) % 65536;
      if (sgn && v >= 32768) v = v + 32'hFFFF0000;
      return v;
    end
    return r;
  endfunction

  task automatic exp_idle();
    e_force = 0; e_req = 0; e_we = 0; e_addr = 0; e_be = 0; e_wdata = 0;
    e_valid = 0; e_err = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_ex();
    ex_is_store = 1'($urandom); ex_size = 2'($urandom); ex_signed = 1'($urandom);
    ex_addr = $urandom; ex_wdata = $urandom; ex_rd = 4'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      exmem_wen = 0;
      dmem.dmem_ready = 1'($urandom);
      dmem.dmem_rdata = $urandom;
      exp_idle();
      step();
    end
    dmem.dmem_ready = 0;
  endtask

  // One MEM-stage operation. lat = number of ACCESS cycles with ready low
  // before ready rises; lat >= TO_LIM means the access times out.
  task automatic txn(input bit st, input logic [1:0] sz, input bit sgn,
                     input logic [31:0] a, input logic [31:0] wd, input logic [3:0] rd,
                     input int lat, input logic [31:0] rdata, input bit abuse);
    int n;
    exmem_wen = 1; ex_is_store = st; ex_size = sz; ex_signed = sgn;
    ex_addr = a; ex_wdata = wd; ex_rd = rd;
    dmem.dmem_ready = 1'($urandom); dmem.dmem_rdata = $urandom;
    exp_idle();
    step();
    exmem_wen = 0;
    junk_ex();
    e_wb_rd = rd;
    if (!m_mis(sz, a)) begin
      n = (lat < TO_LIM) ? lat + 1 : TO_LIM;
      for (int i = 0; i < n; i++) begin
        e_force = 1; e_req = 1; e_we = st; e_addr = a & ~32'h3;
        e_be = m_be(sz, a); e_wdata = st ? m_wd(sz, wd) : 32'h0;
        e_valid = 0; e_err = 0;
        dmem.dmem_ready = (i == lat);
        dmem.dmem_rdata = (i == lat) ? rdata : $urandom;
        if (abuse) begin exmem_wen = 1'($urandom); junk_ex(); end
        step();
      end
      exp_idle();
      if (lat < TO_LIM) begin
        e_valid = !st;
        if (!st) e_wb_data = m_ld(sz, sgn, a, rdata);
      end else begin
        e_err = 1;
      end
    end else begin
      exp_idle();
      e_err = 1;
    end
    // DONE cycle: ready here must be ignored, wen here is a violation
    dmem.dmem_ready = 1'($urandom); dmem.dmem_rdata = $urandom;
    exmem_wen = abuse ? 1'($urandom) : 1'b0;
    step();
    exmem_wen = 0; dmem.dmem_ready = 0;
    exp_idle();
  endtask

  int f0, r0, m0;

  initial begin
    reset = 1; exmem_wen = 0; junk_ex();
    dmem.dmem_ready = 0; dmem.dmem_rdata = 0;
    repeat (2) step();
    exp_idle(); e_wb_data = 0; e_wb_rd = 0;
    chk_en = 1;
    dmem.dmem_ready = 1;   // ready under reset must be ignored
    step();
    reset = 0; dmem.dmem_ready = 0;
    idle(1);

    // word load, ready one cycle after req
    f0 = force_cnt;
    txn(0, 2'd2, 0, 32'h100, 32'h0, 4'd5, 1, 32'hDEADBEEF, 0);
    chk("t1_force_cycles", 32'(force_cnt - f0), 32'd2);
    chk("t1_wb_data", wb_data, 32'hDEADBEEF);
    chk("t1_wb_rd", 32'(wb_rd), 32'd5);
    idle(1);

    // signed then unsigned byte load from lane 3
    txn(0, 2'd0, 1, 32'h103, 32'h0, 4'd7, 0, 32'h80FF7F01, 0);
    chk("t2_addr", last_addr, 32'h100);
    chk("t2_sbyte", wb_data, 32'hFFFFFF80);
    txn(0, 2'd0, 0, 32'h103, 32'h0, 4'd7, 2, 32'h80FF7F01, 0);
    chk("t2_ubyte", wb_data, 32'h00000080);

    // halfword store, ready low for 3 cycles
    r0 = req_cnt;
    txn(1, 2'd1, 0, 32'h206, 32'h0000ABCD, 4'd2, 3, 32'h0, 0);
    chk("t3_be", 32'(last_be), 32'hC);
    chk("t3_wdata", last_wdata, 32'hABCDABCD);
    chk("t3_we", 32'(last_we), 32'd1);
    chk("t3_req_cycles", 32'(req_cnt - r0), 32'd4);
    chk("t3_wb_data_held", wb_data, 32'h00000080);

    // misaligned word load
    f0 = force_cnt; r0 = req_cnt; m0 = err_cnt;
    txn(0, 2'd2, 0, 32'h101, 32'h0, 4'd3, 0, 32'h0, 0);
    chk("t4_no_req", 32'(req_cnt - r0), 32'd0);
    chk("t4_no_force", 32'(force_cnt - f0), 32'd0);
    chk("t4_err_pulses", 32'(err_cnt - m0), 32'd1);
    idle(1);

    // reset in the 2nd ACCESS cycle
    exmem_wen = 1; ex_is_store = 0; ex_size = 2'd2; ex_signed = 0;
    ex_addr = 32'h40; ex_rd = 4'd9; exp_idle();
    step();
    exmem_wen = 0; e_wb_rd = 4'd9;
    e_force = 1; e_req = 1; e_we = 0; e_addr = 32'h40; e_be = 4'hF; e_wdata = 0;
    dmem.dmem_ready = 0;
    step();
    reset = 1;
    step();
    exp_idle(); e_wb_data = 0; e_wb_rd = 0;
    chk("t5_req_dropped", 32'(dmem.dmem_req), 32'd0);
    reset = 0; dmem.dmem_ready = 1; dmem.dmem_rdata = 32'h12345678;
    step();
    dmem.dmem_ready = 0;
    idle(2);

`ifdef MEM_TIMEOUT_EN
    f0 = force_cnt; m0 = err_cnt;
    txn(0, 2'd2, 0, 32'h300, 32'h0, 4'd4, 1000, 32'h0, 0);
    chk("t6_force_cycles", 32'(force_cnt - f0), 32'd4);
    chk("t6_err_pulses", 32'(err_cnt - m0), 32'd1);
    idle(1);
`endif

    // randomized traffic with wen abuse and stray ready pulses
    for (int k = 0; k < 150; k++) begin
      txn(1'($urandom), 2'($urandom), 1'($urandom),
          32'h1000 + ($urandom % 64), $urandom, 4'($urandom),
          $urandom_range(0, 3), $urandom, ($urandom % 4) == 0);
      idle($urandom_range(0, 2));
    end

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
